// File: rtl/nios2_debug_cmd_sync_if.sv
// Command bus between the sysclk debug receiver and its consumer.
// The head entry is first-word-fall-through and is popped by valid & ready.
interface nios2_debug_cmd_sync_if #(
  parameter int IR_W   = 2,
  parameter int DATA_W = 38
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [IR_W-1:0]   cmd_ir;
  logic [DATA_W-1:0] cmd_data;

  modport master (output cmd_valid, output cmd_ir, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_ir, input cmd_data, output cmd_ready);
endinterface

// File: rtl/nios2_debug_cmd_sync.sv
// Sysclk-side Nios II debug receiver: synchronises JTAG update strobes, queues scans, decodes pops.
// Optional feature: define NIOS2_DBG_CMD_UIR_FLUSH_EN to let a vs_uir rising edge flush the queue.
module nios2_debug_cmd_sync #(
  parameter int IR_W        = 2,
  parameter int DATA_W      = 38,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ACT_BIT     = 37
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [IR_W-1:0]         ir_in,
  input  logic [DATA_W-1:0]       sr,
  input  logic                    vs_udr,
  input  logic                    vs_uir,
  nios2_debug_cmd_sync_if.master  cmd,
  output logic [2**IR_W-1:0]      take_action,
  output logic [2**IR_W-1:0]      take_no_action,
  output logic [$clog2(DEPTH):0]  cmd_count,
  output logic                    overflow,
  input  logic                    ovf_clr
);
  localparam int AW      = $clog2(DEPTH);
  localparam int PW      = AW + 1;
  localparam int ENTRY_W = IR_W + DATA_W;
  localparam int ARM_W   = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] udr_sync, uir_sync;
  logic                   udr_prev, uir_prev;
  logic [ARM_W-1:0]       arm_cnt;
  logic                   armed, udr_rise, uir_rise;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      udr_sync <= '0;
      uir_sync <= '0;
      udr_prev <= 1'b0;
      uir_prev <= 1'b0;
      arm_cnt  <= '0;
    end else begin
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      udr_prev <= udr_sync[SYNC_STAGES-1];
      uir_prev <= uir_sync[SYNC_STAGES-1];
      if (!armed) arm_cnt <= arm_cnt + ARM_W'(1);
    end
  end

  // Edges are ignored until the chain has flushed, so a strobe held across reset is not a command.
  assign armed    = (arm_cnt == ARM_DONE);
  assign udr_rise = armed & udr_sync[SYNC_STAGES-1] & ~udr_prev;
  assign uir_rise = armed & uir_sync[SYNC_STAGES-1] & ~uir_prev;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic               empty, full, pop, flush, push_ok, pop_ok, ovf_set;
  logic [ENTRY_W-1:0] head;

`ifdef NIOS2_DBG_CMD_UIR_FLUSH_EN
  assign flush = uir_rise;
`else
  // vs_uir is still synchronised but has no effect in this build.
  logic unused_uir_rise;
  assign unused_uir_rise = uir_rise;
  assign flush = 1'b0;
`endif

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = ~empty & cmd.cmd_ready;
  assign pop_ok  = pop & ~flush;
  assign push_ok = udr_rise & (~full | pop) & ~flush;
  assign ovf_set = udr_rise & full & ~pop & ~flush;

  // NOTE: the storage array has no reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= {ir_in, sr};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)        overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  assign head          = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign cmd.cmd_valid = ~empty;
  assign cmd.cmd_ir    = head[ENTRY_W-1:DATA_W];
  assign cmd.cmd_data  = head[DATA_W-1:0];
  assign cmd_count     = wr_ptr - rd_ptr;

  logic [2**IR_W-1:0] pop_onehot;

  // NOTE: default first so the decoder stays purely combinational (no latch).
  always_comb begin
    pop_onehot = '0;
    pop_onehot[cmd.cmd_ir] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      take_action    <= '0;
      take_no_action <= '0;
    end else begin
      take_action    <= (pop_ok &&  cmd.cmd_data[ACT_BIT]) ? pop_onehot : '0;
      take_no_action <= (pop_ok && !cmd.cmd_data[ACT_BIT]) ? pop_onehot : '0;
    end
  end
endmodule

// File: tb/tb_nios2_debug_cmd_sync.sv
// Randomised bench for nios2_debug_cmd_sync against a queue-based reference model.
// Honours NIOS2_DBG_CMD_UIR_FLUSH_EN the same way the design does.
module tb_nios2_debug_cmd_sync;
  localparam int IR_W = 2, DATA_W = 38, DEPTH = 4, S = 2, ACT_BIT = 37;
  localparam int N_CH = 2**IR_W;
  localparam int CW   = $clog2(DEPTH) + 1;

  typedef logic [IR_W+DATA_W-1:0] entry_t;
  typedef struct { int at; entry_t e; } sched_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, vs_udr, vs_uir, ovf_clr, overflow;
  logic [IR_W-1:0]   ir_in;
  logic [DATA_W-1:0] sr;
  logic [N_CH-1:0]   take_action, take_no_action;
  logic [CW-1:0]     cmd_count;

  nios2_debug_cmd_sync_if #(.IR_W(IR_W), .DATA_W(DATA_W)) cmd_bus ();

  nios2_debug_cmd_sync #(
    .IR_W(IR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .SYNC_STAGES(S), .ACT_BIT(ACT_BIT)
  ) dut (
    .clk(clk), .reset(reset), .ir_in(ir_in), .sr(sr), .vs_udr(vs_udr), .vs_uir(vs_uir),
    .cmd(cmd_bus), .take_action(take_action), .take_no_action(take_no_action),
    .cmd_count(cmd_count), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  int checks = 0, errors = 0, cyc = 0;
  entry_t mq[$];
  sched_t sched[$];
  int flush_at = -1;
  logic m_ovf;
  logic [N_CH-1:0] m_ta, m_tna;
  bit pop_on_push;
  int ready_div;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: one update per clock edge, from the inputs held before that edge.
  task automatic model_edge();
    bit push, pop, fl, set;
    entry_t e;
    push = (sched.size() > 0) && (sched[0].at == cyc);
    fl   = (flush_at == cyc);
    pop  = (mq.size() > 0) && cmd_bus.cmd_ready;
    set  = 0;
    m_ta = '0;
    m_tna = '0;
    if (reset) begin
      mq.delete();
      sched.delete();
      flush_at = -1;
      m_ovf = 1'b0;
    end else begin
      if (push) begin
        e = sched[0].e;
        sched.delete(0);
      end
      if (fl) begin
        mq.delete();
      end else begin
        if (pop) begin
          entry_t h;
          h = mq.pop_front();
          if (h[ACT_BIT]) m_ta[h[DATA_W+:IR_W]] = 1'b1;
          else            m_tna[h[DATA_W+:IR_W]] = 1'b1;
        end
        if (push) begin
          if (mq.size() < DEPTH) mq.push_back(e);
          else set = 1;
        end
      end
      if (set)          m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
    end
  endtask

  task automatic compare();
    entry_t h;
    h = (mq.size() > 0) ? mq[0] : '0;
    check("valid",          cmd_bus.cmd_valid, mq.size() > 0);
    check("count",          cmd_count, mq.size());
    check("head_ir",        cmd_bus.cmd_ir, h[DATA_W+:IR_W]);
    check("head_data",      cmd_bus.cmd_data, h[DATA_W-1:0]);
    check("take_action",    take_action, m_ta);
    check("take_no_action", take_no_action, m_tna);
    check("overflow",       overflow, m_ovf);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    compare();
    if (pop_on_push) cmd_bus.cmd_ready = (sched.size() > 0) && (sched[0].at == cyc + 1);
  endtask

  task automatic rstep();
    cmd_bus.cmd_ready = ($urandom_range(0, ready_div - 1) == 0);
    ovf_clr = ($urandom_range(0, 15) == 0);
    step();
  endtask

  // vs_udr first sampled at the next edge; the entry lands S edges after that.
  task automatic raise_udr(input logic [IR_W-1:0] ir, input logic [DATA_W-1:0] d);
    ir_in  = ir;
    sr     = d;
    vs_udr = 1'b1;
    sched.push_back('{cyc + 1 + S, {ir, d}});
  endtask

  task automatic scan(input logic [IR_W-1:0] ir, input logic [DATA_W-1:0] d);
    raise_udr(ir, d);
    repeat (S + 1) step();
    vs_udr = 1'b0;
    repeat (S + 1) step();
  endtask

  task automatic rand_scan();
    scan(IR_W'($urandom_range(0, N_CH - 1)), DATA_W'({$urandom, $urandom}));
  endtask

  task automatic drain();
    cmd_bus.cmd_ready = 1'b1;
    repeat (DEPTH + 1) step();
    cmd_bus.cmd_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; vs_udr = 1'b0; vs_uir = 1'b0; ovf_clr = 1'b0;
    ir_in = '0; sr = '0; cmd_bus.cmd_ready = 1'b0;
    pop_on_push = 0; ready_div = 8;
    m_ovf = 1'b0; m_ta = '0; m_tna = '0;
    repeat (3) step();
    reset = 1'b0;
    repeat (S + 3) step();
    check("reset_count", cmd_count, 0);
    check("reset_valid", cmd_bus.cmd_valid, 0);

    // Single action scan.
    scan(2'd2, 38'h25_1234_5678);
    check("single_valid", cmd_bus.cmd_valid, 1);
    check("single_data", cmd_bus.cmd_data, 38'h25_1234_5678);
    cmd_bus.cmd_ready = 1'b1;
    step();
    cmd_bus.cmd_ready = 1'b0;
    check("single_take_action", take_action, 4'b0100);
    step();
    check("single_pulse_width", take_action, 4'b0000);

    // No-action scan.
    scan(2'd0, 38'h00_0BAD_F00D);
    cmd_bus.cmd_ready = 1'b1;
    step();
    cmd_bus.cmd_ready = 1'b0;
    check("noact_tna", take_no_action, 4'b0001);
    check("noact_ta", take_action, 4'b0000);
    step();

    // Overflow: five scans into four entries.
    repeat (5) rand_scan();
    check("ovf_count", cmd_count, 4);
    check("ovf_flag", overflow, 1);
    drain();
    check("ovf_sticky", overflow, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_cleared", overflow, 0);

    // Full queue with push and pop on the same edge, across pointer wrap.
    repeat (4) rand_scan();
    pop_on_push = 1;
    repeat (10) rand_scan();
    pop_on_push = 0;
    cmd_bus.cmd_ready = 1'b0;
    check("full_pp_count", cmd_count, 4);
    check("full_pp_ovf", overflow, 0);
    drain();

    // Reset mid-operation with a pop pending and vs_udr held high through release.
    repeat (2) rand_scan();
    cmd_bus.cmd_ready = 1'b1;
    reset = 1'b1;
    vs_udr = 1'b1;
    ir_in = 2'd3;
    repeat (3) step();
    cmd_bus.cmd_ready = 1'b0;
    reset = 1'b0;
    repeat (10) step();
    check("rst_high_count", cmd_count, 0);
    check("rst_high_valid", cmd_bus.cmd_valid, 0);
    vs_udr = 1'b0;
    repeat (S + 1) step();

    // vs_uir flush with three entries held.
    repeat (3) rand_scan();
    vs_uir = 1'b1;
`ifdef NIOS2_DBG_CMD_UIR_FLUSH_EN
    flush_at = cyc + 1 + S;
`endif
    repeat (S + 1) step();
    vs_uir = 1'b0;
    repeat (S + 1) step();
`ifdef NIOS2_DBG_CMD_UIR_FLUSH_EN
    check("flush_count", cmd_count, 0);
    check("flush_valid", cmd_bus.cmd_valid, 0);
`else
    check("noflush_count", cmd_count, 3);
`endif
    drain();

    // Random traffic: slow consumer first, then a faster one.
    for (int n = 0; n < 40; n++) begin
      raise_udr(IR_W'($urandom_range(0, N_CH - 1)), DATA_W'({$urandom, $urandom}));
      repeat (S + 1) rstep();
      vs_udr = 1'b0;
      repeat (S + 1 + $urandom_range(0, 3)) rstep();
      if (n == 20) ready_div = 2;
    end
    ovf_clr = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
